// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings,
// the per-stage control bundle and the hazard decode used in RUN and MEM_WAIT.
package pipe_ctrl_defs;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
    } pipe_ctrl_t;

    // Every register held, nothing injected: used for IDLE, ERROR and cache stalls.
    localparam pipe_ctrl_t CTRL_FREEZE = '0;

    // Controls when the data cache is not stalling. A load-use stall suppresses
    // the branch flush so the branch is re-evaluated with forwarded operands.
    function automatic pipe_ctrl_t hazard_ctrl(input logic loaduse, input logic branch_flush);
        pipe_ctrl_t c;
        c.pc_write     = ~loaduse;
        c.if_id_write  = ~loaduse;
        c.if_id_flush  = ~loaduse & branch_flush;
        c.id_ex_write  = 1'b1;
        c.id_ex_bubble = loaduse;
        c.ex_mem_write = 1'b1;
        c.mem_wb_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics: sticks at all-ones, never wraps.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges cache-miss, load-use
// and branch-flush requests into per-stage controls, with timeout and perf counters.
module pipeline_stall_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             loaduse_i,
    input  logic             branch_flush_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic [1:0]       state_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next_state;
    pipe_ctrl_t       w_ctrl;
    logic             w_wait_inc;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_timeout;
    logic             w_stall_inc;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = CTRL_FREEZE;
        w_wait_inc   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall_i) w_next_state = ST_MEM_WAIT;
                else             w_ctrl = hazard_ctrl(loaduse_i, branch_flush_i);
            end
            ST_MEM_WAIT: begin
                if (mem_stall_i) begin
                    w_wait_inc = 1'b1;
                    if (r_wait_cnt == TIMEOUT_LAST) w_next_state = ST_ERROR;
                end else begin
                    // Release cycle: the stage registers move again this very cycle.
                    w_ctrl       = hazard_ctrl(loaduse_i, branch_flush_i);
                    w_next_state = ST_RUN;
                end
            end
            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (rst_i) w_ctrl = CTRL_FREEZE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_inc ? r_wait_cnt + CNT_W'(1) : '0;
            if (w_next_state == ST_ERROR) r_mem_timeout <= 1'b1;
        end
    end

    assign w_stall_inc = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && !w_ctrl.pc_write;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_stall_inc),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_ctrl.if_id_flush),
        .count_o (flush_cnt_o)
    );

    assign pc_write_o     = w_ctrl.pc_write;
    assign if_id_write_o  = w_ctrl.if_id_write;
    assign if_id_flush_o  = w_ctrl.if_id_flush;
    assign id_ex_write_o  = w_ctrl.id_ex_write;
    assign id_ex_bubble_o = w_ctrl.id_ex_bubble;
    assign ex_mem_write_o = w_ctrl.ex_mem_write;
    assign mem_wb_write_o = w_ctrl.mem_wb_write;
    assign state_o        = r_state;
    assign mem_timeout_o  = r_mem_timeout;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline with data cache. Merges three inputs into one set of per-stage register write-enable, bubble and flush controls:
- load-use stall request from the hazard detection unit
- data-cache miss stall
- ID-stage branch-taken flush

Also tracks a start/run lifecycle, times out stuck memory accesses, and keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of stall_cnt_o and flush_cnt_o
MEM_TIMEOUT, 255, max consecutive cycles in MEM_WAIT before error; must be >=1 and < 2^CNT_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous active-high
start_i  in  1  leave IDLE and begin execution
loaduse_i  in  1  load-use stall request from hazard detection
branch_flush_i  in  1  branch taken in ID; squash IF/ID
mem_stall_i  in  1  data cache busy servicing miss/writeback
pc_write_o  out  1  PC register write enable
if_id_write_o  out  1  IF/ID write enable
if_id_flush_o  out  1  IF/ID clear to NOP
id_ex_write_o  out  1  ID/EX write enable
id_ex_bubble_o  out  1  select zero control bits into ID/EX
ex_mem_write_o  out  1  EX/MEM write enable
mem_wb_write_o  out  1  MEM/WB write enable
state_o  out  2  current FSM state encoding
mem_timeout_o  out  1  sticky timeout error
stall_cnt_o  out  CNT_W  cycles with any stall active in RUN/MEM_WAIT
flush_cnt_o  out  CNT_W  number of cycles if_id_flush_o asserted

Behaviour:
- FSM states: IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3. Reset -> IDLE.
- Reset values: all write enables 0, flush 0, bubble 0, mem_timeout_o 0, counters 0, wait counter 0.
- IDLE
  - All write enables 0, bubble 0, flush 0.
  - start_i=1 -> RUN next cycle.
- RUN: controls are combinational from inputs in the same cycle (zero latency). Priority is mem > loaduse > branch.
  - mem_stall_i=1: all five write enables 0, bubble 0, flush 0. Next state MEM_WAIT.
  - else loaduse_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. Other writes 1. flush 0, because the branch is suppressed and re-evaluated next cycle with forwarded operands.
  - else branch_flush_i=1: if_id_flush_o=1. All writes 1.
  - else: all writes 1, bubble 0, flush 0.
- MEM_WAIT
  - While mem_stall_i=1: full freeze as above, and the wait counter increments.
  - mem_stall_i=0: outputs this same cycle follow RUN rules for loaduse_i/branch_flush_i. Next state RUN; wait counter cleared.
  - Wait counter reaching MEM_TIMEOUT while mem_stall_i=1: next state ERROR, mem_timeout_o=1 from next cycle.
- ERROR
  - Full freeze; mem_timeout_o held 1.
  - Exit only by rst_i. start_i ignored.
- start_i in RUN/MEM_WAIT is ignored.
- Counters
  - stall_cnt_o +1 on each cycle in RUN/MEM_WAIT where pc_write_o=0.
  - flush_cnt_o +1 on each cycle where if_id_flush_o=1.
  - Both saturate at all-ones, with no wrap.
- rst_i asserted mid-MEM_WAIT or in any state: next cycle is IDLE with reset values. rst_i has priority over every input.
- Outputs in IDLE/ERROR ignore loaduse_i and branch_flush_i.

Decomposition:
- Shared package/header (pipe_ctrl_defs): state encodings ST_IDLE/ST_RUN/ST_MEM_WAIT/ST_ERROR, 2-bit state width.
- One natural sub-module: sat_counter (width param, inc_i, clr via rst_i, count_o), instantiated twice.
- FSM and output decode stay in the top module.

Test Plan:
1. Reset, then start_i pulse: state_o 0->1. In RUN with no requests, all writes =1 and counters stay 0.
2. RUN, loaduse_i=1 for 1 cycle: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 that cycle. Next cycle all writes 1; stall_cnt_o=1.
3. RUN, loaduse_i=1 and branch_flush_i=1 together: if_id_flush_o=0, bubble=1. Next cycle branch_flush_i=1 only: flush=1, flush_cnt_o=1.
4. mem_stall_i high for 10 cycles with loaduse_i also high: all writes 0 for 10 cycles and state_o=2. On the release cycle, loaduse controls apply and state returns to 1. stall_cnt_o=11.
5. MEM_TIMEOUT=4, mem_stall_i held high: ERROR after 4 MEM_WAIT cycles and mem_timeout_o=1. Dropping mem_stall_i keeps the freeze; rst_i returns to IDLE with mem_timeout_o=0.
6. CNT_W=3, hold branch_flush_i high for 10 RUN cycles: flush_cnt_o saturates at 7.
